// File: rtl/iir_mon_pkg.sv
// iir_mon_pkg: shared state encoding, default sizes and saturating increment for the IIR result monitor.
package iir_mon_pkg;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   localparam int NB_DEF = 12;
   localparam int DEPTH_DEF = 8;
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
      return (v == max) ? v : v + 32'd1;
   endfunction
endpackage

// File: rtl/mon_sync_fifo.sv
// mon_sync_fifo: synchronous FIFO with registered full/empty, extra pointer bit for wrap tracking.
module mon_sync_fifo
   import iir_mon_pkg::*;
#(
   parameter int NB = NB_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [NB-1:0] din,
   output logic [NB-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic          drop
);
   localparam int AW = $clog2(DEPTH);
   logic [NB-1:0] mem [DEPTH];
   logic [AW:0] wr, rd, wr_nxt, rd_nxt;
   logic do_push, do_pop;
   // A push into a full FIFO still lands when the same cycle frees an entry.
   assign do_pop = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign drop = push & full & ~do_pop;
   assign wr_nxt = wr + (AW+1)'(do_push);
   assign rd_nxt = rd + (AW+1)'(do_pop);
   assign dout = mem[rd[AW-1:0]];
   always_ff @(posedge clk) begin
      if (rst) begin
         wr <= '0;
         rd <= '0;
         empty <= 1'b1;
         full <= 1'b0;
      end else begin
         wr <= wr_nxt;
         rd <= rd_nxt;
         empty <= wr_nxt == rd_nxt;
         full <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      end
   end
   always_ff @(posedge clk)
      if (do_push) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/iir_result_monitor.sv
// iir_result_monitor: buffers filter and golden streams, compares pairs in order, counts and flags completion.
// Define MON_TOLERANCE_EN to accept differences of +/-1 LSB.
module iir_result_monitor
   import iir_mon_pkg::*;
#(
   parameter int NB = NB_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int N_SAMPLES = 256,
   parameter int CW = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic [NB-1:0] DIN,
   input  logic          VIN,
   input  logic [NB-1:0] EXP_DIN,
   input  logic          EXP_VIN,
   output logic          ERR,
   output logic [CW-1:0] SAMPLE_CNT,
   output logic [CW-1:0] MISMATCH_CNT,
   output logic          OVF,
   output logic          DONE
);
   localparam logic [31:0] CMAX = 32'({CW{1'b1}});
   state_t state;
   logic run, pop, mism;
   logic d_empty, e_empty, d_full, e_full, d_drop, e_drop;
   logic [NB-1:0] d_q, e_q;
   logic signed [NB:0] diff;
   logic [CW-1:0] s_nxt, m_nxt;
   assign run = state == S_RUN;
   assign pop = run & ~d_empty & ~e_empty;
   mon_sync_fifo #(.NB(NB), .DEPTH(DEPTH)) u_dut_fifo (
      .clk(CLK), .rst(RST), .push(VIN & run), .pop(pop), .din(DIN),
      .dout(d_q), .full(d_full), .empty(d_empty), .drop(d_drop));
   mon_sync_fifo #(.NB(NB), .DEPTH(DEPTH)) u_exp_fifo (
      .clk(CLK), .rst(RST), .push(EXP_VIN & run), .pop(pop), .din(EXP_DIN),
      .dout(e_q), .full(e_full), .empty(e_empty), .drop(e_drop));
   // Sign-extend by one bit so opposite-sign extremes cannot wrap to a false match.
   assign diff = $signed({d_q[NB-1], d_q}) - $signed({e_q[NB-1], e_q});
`ifdef MON_TOLERANCE_EN
   assign mism = !(diff == '0 || diff == {{NB{1'b0}}, 1'b1} || diff == '1);
`else
   assign mism = diff != '0;
`endif
   assign s_nxt = CW'(sat_inc(32'(SAMPLE_CNT), CMAX));
   assign m_nxt = CW'(sat_inc(32'(MISMATCH_CNT), CMAX));
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_IDLE;
         ERR <= 1'b0;
         SAMPLE_CNT <= '0;
         MISMATCH_CNT <= '0;
         OVF <= 1'b0;
         DONE <= 1'b0;
      end else begin
         ERR <= pop & mism;
         if (pop) SAMPLE_CNT <= s_nxt;
         if (pop & mism) MISMATCH_CNT <= m_nxt;
         if (d_drop | e_drop) OVF <= 1'b1;
         if (state == S_IDLE && START) state <= S_RUN;
         if (pop && s_nxt == CW'(N_SAMPLES)) begin
            state <= S_DONE;
            DONE <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_iir_result_monitor.sv
// tb_iir_result_monitor: directed stimulus against a queue-based model of the monitor, plus literal pins.
module tb_iir_result_monitor;
   localparam int NB = 12, DEPTH = 8, NS = 256, CW = 16;
`ifdef MON_TOLERANCE_EN
   localparam bit TOL = 1'b1;
`else
   localparam bit TOL = 1'b0;
`endif
   logic CLK = 0, RST = 1, START = 0, VIN = 0, EXP_VIN = 0;
   logic [NB-1:0] DIN = '0, EXP_DIN = '0;
   logic ERR, OVF, DONE;
   logic [CW-1:0] SAMPLE_CNT, MISMATCH_CNT;
   int checks = 0, errors = 0, stepn = 0, err_cnt = 0, err_step = -1, s10 = 0;
   int dq[$], eq[$];
   int m_state = 0, m_scnt = 0, m_mcnt = 0;
   bit m_err = 0, m_ovf = 0;

   iir_result_monitor #(.NB(NB), .DEPTH(DEPTH), .N_SAMPLES(NS), .CW(CW)) dut (
      .CLK(CLK), .RST(RST), .START(START), .DIN(DIN), .VIN(VIN), .EXP_DIN(EXP_DIN),
      .EXP_VIN(EXP_VIN), .ERR(ERR), .SAMPLE_CNT(SAMPLE_CNT), .MISMATCH_CNT(MISMATCH_CNT),
      .OVF(OVF), .DONE(DONE));

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (step %0d)", name, act, exp, stepn);
      end
   endtask

   // Model of one rising edge: pairs leave in arrival order, only entries already held can be paired.
   task automatic model_edge();
      bit pop;
      int a, b, d;
      if (RST) begin
         dq.delete(); eq.delete();
         m_state = 0; m_scnt = 0; m_mcnt = 0; m_err = 0; m_ovf = 0;
         return;
      end
      pop = m_state == 1 && dq.size() > 0 && eq.size() > 0;
      m_err = 0;
      if (pop) begin
         a = dq.pop_front();
         b = eq.pop_front();
         d = a - b;
         if (m_scnt < 65535) m_scnt++;
         if (TOL ? (d > 1 || d < -1) : (d != 0)) begin
            m_err = 1;
            if (m_mcnt < 65535) m_mcnt++;
         end
      end
      if (m_state == 1) begin
         if (VIN) begin
            if (dq.size() < DEPTH) dq.push_back(int'($signed(DIN)));
            else m_ovf = 1;
         end
         if (EXP_VIN) begin
            if (eq.size() < DEPTH) eq.push_back(int'($signed(EXP_DIN)));
            else m_ovf = 1;
         end
      end
      if (m_state == 0 && START) m_state = 1;
      else if (m_state == 1 && pop && m_scnt == NS) m_state = 2;
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
      stepn++;
      if (ERR) begin
         err_cnt++;
         err_step = stepn;
      end
      chk("err", int'(ERR), int'(m_err));
      chk("sample_cnt", int'(SAMPLE_CNT), m_scnt);
      chk("mismatch_cnt", int'(MISMATCH_CNT), m_mcnt);
      chk("ovf", int'(OVF), int'(m_ovf));
      chk("done", int'(DONE), int'(m_state == 2));
   endtask

   task automatic drive(input logic v, input int d, input logic ev, input int e);
      VIN = v; DIN = NB'(d); EXP_VIN = ev; EXP_DIN = NB'(e);
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
   endtask

   task automatic do_reset();
      RST = 1; idle(2); RST = 0;
      err_cnt = 0;
   endtask

   task automatic do_start();
      START = 1; idle(1); START = 0;
   endtask

   task automatic skew(input int d);
      do_reset(); do_start();
      for (int t = 0; t < 20 + d; t++) drive(t < 20, t, t >= d && t - d < 20, t - d);
      idle(3);
   endtask

   initial begin
      idle(2);
      RST = 0;
      chk("rst_sample_cnt", int'(SAMPLE_CNT), 0);
      chk("rst_done", int'(DONE), 0);
      // Aligned streams, then valid data after DONE must not be compared.
      do_start();
      for (int i = 0; i < NS; i++) drive(1, i * 7 - 900, 1, i * 7 - 900);
      for (int i = 0; i < 5; i++) drive(1, i, 1, i + 3);
      idle(3);
      chk("aligned_cnt", int'(SAMPLE_CNT), 256);
      chk("aligned_mis", int'(MISMATCH_CNT), 0);
      chk("aligned_done", int'(DONE), 1);
      chk("aligned_ovf", int'(OVF), 0);
      chk("aligned_err_pulses", err_cnt, 0);
      // Single off-by-one error at pair 10.
      do_reset(); do_start();
      for (int i = 0; i < 20; i++) begin
         if (i == 10) begin
            drive(1, 'h7FF, 1, 'h7FE);
            s10 = stepn;
         end else drive(1, i, 1, i);
      end
      idle(3);
      chk("single_cnt", int'(SAMPLE_CNT), 20);
`ifdef MON_TOLERANCE_EN
      chk("single_mis", int'(MISMATCH_CNT), 0);
      chk("single_err_pulses", err_cnt, 0);
`else
      chk("single_mis", int'(MISMATCH_CNT), 1);
      chk("single_err_pulses", err_cnt, 1);
      chk("single_err_latency", err_step, s10 + 1);
`endif
      // Opposite-sign extremes must never compare equal.
      do_reset(); do_start();
      drive(1, 'h800, 1, 'h7FF);
      idle(3);
      chk("sign_mis", int'(MISMATCH_CNT), 1);
      chk("sign_err_pulses", err_cnt, 1);
      // Golden stream lagging so the filter FIFO fills exactly, then lagging two samples more.
      skew(DEPTH - 1);
      chk("skew_ok_ovf", int'(OVF), 0);
      chk("skew_ok_cnt", int'(SAMPLE_CNT), 20);
      chk("skew_ok_mis", int'(MISMATCH_CNT), 0);
      skew(DEPTH + 1);
      chk("skew_ovf", int'(OVF), 1);
      chk("skew_ovf_cnt", int'(SAMPLE_CNT), 18);
      chk("skew_ovf_mis", int'(MISMATCH_CNT), 10);
      // Gating: data before START and on the START cycle is ignored, re-START in RUN is harmless.
      do_reset();
      for (int i = 0; i < 3; i++) drive(1, i, 1, i + 1);
      START = 1; drive(1, 5, 1, 6); START = 0;
      for (int i = 0; i < 4; i++) drive(1, i, 1, i);
      START = 1; drive(1, 9, 1, 9); START = 0;
      for (int i = 0; i < 2; i++) drive(1, i, 1, i);
      idle(3);
      chk("gate_cnt", int'(SAMPLE_CNT), 7);
      chk("gate_mis", int'(MISMATCH_CNT), 0);
      chk("gate_done", int'(DONE), 0);
      // Reset in the middle of a run, then restart from zero.
      do_reset(); do_start();
      for (int i = 0; i < 50; i++) drive(1, i, 1, i ^ 1);
      chk("mid_cnt", int'(SAMPLE_CNT), 49);
      RST = 1; drive(1, 1, 1, 2); RST = 0;
      chk("mid_rst_cnt", int'(SAMPLE_CNT), 0);
      chk("mid_rst_mis", int'(MISMATCH_CNT), 0);
      chk("mid_rst_err", int'(ERR), 0);
      drive(1, 3, 1, 3);
      idle(2);
      chk("mid_idle_cnt", int'(SAMPLE_CNT), 0);
      do_start();
      for (int i = 0; i < 5; i++) drive(1, i, 1, i);
      idle(3);
      chk("restart_cnt", int'(SAMPLE_CNT), 5);
      chk("restart_mis", int'(MISMATCH_CNT), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
